// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying a datapath payload and a control payload.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 4
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   // Producer side drives valid/payload, consumer side drives ready.
   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and a saturating backpressure cycle counter.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 4,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             cnt_clr_i,
   output logic [CNT_W-1:0] stall_cnt_o,
   pipe_stage_reg_if.slave  in_if,
   pipe_stage_reg_if.master out_if
);

   logic              out_vld;
   logic              in_rdy;
   logic [DATA_W-1:0] head_data;
   logic [CTRL_W-1:0] head_ctrl;
   logic              in_xfer;
   logic              out_xfer;

   // in_rdy already excludes flush/reset cycles, so a dropped input never counts.
   assign in_xfer  = in_if.valid && in_rdy;
   assign out_xfer = out_vld && out_if.ready;

   assign in_if.ready  = in_rdy;
   assign out_if.valid = out_vld;
   assign out_if.data  = head_data;
   // Bubbles must never carry live control bits downstream.
   assign out_if.ctrl  = out_vld ? head_ctrl : '0;

   if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

      state_e            state_q;
      logic              out_vld_q;
      logic              in_rdy_q;
      logic [DATA_W-1:0] head_data_q;
      logic [CTRL_W-1:0] head_ctrl_q;
      logic [DATA_W-1:0] skid_data_q;
      logic [CTRL_W-1:0] skid_ctrl_q;

      assign out_vld   = out_vld_q;
      assign in_rdy    = in_rdy_q && !flush_i && !rst_i;
      assign head_data = head_data_q;
      assign head_ctrl = head_ctrl_q;

      // Skid FSM: head/skid storage with registered in_ready, FIFO order kept.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q     <= StEmpty;
            out_vld_q   <= 1'b0;
            in_rdy_q    <= 1'b1;
            head_data_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
         end else if (flush_i) begin
            // Data may stay stale; only validity and control are killed.
            state_q     <= StEmpty;
            out_vld_q   <= 1'b0;
            in_rdy_q    <= 1'b1;
            head_ctrl_q <= '0;
            skid_ctrl_q <= '0;
         end else begin
            unique case (state_q)
               StEmpty: begin
                  if (in_xfer) begin
                     head_data_q <= in_if.data;
                     head_ctrl_q <= in_if.ctrl;
                     out_vld_q   <= 1'b1;
                     state_q     <= StOne;
                  end
               end
               StOne: begin
                  if (in_xfer && !out_xfer) begin
                     skid_data_q <= in_if.data;
                     skid_ctrl_q <= in_if.ctrl;
                     in_rdy_q    <= 1'b0;
                     state_q     <= StFull;
                  end else if (in_xfer && out_xfer) begin
                     head_data_q <= in_if.data;
                     head_ctrl_q <= in_if.ctrl;
                  end else if (out_xfer) begin
                     head_ctrl_q <= '0;
                     out_vld_q   <= 1'b0;
                     state_q     <= StEmpty;
                  end
               end
               StFull: begin
                  if (out_xfer) begin
                     head_data_q <= skid_data_q;
                     head_ctrl_q <= skid_ctrl_q;
                     skid_ctrl_q <= '0;
                     in_rdy_q    <= 1'b1;
                     state_q     <= StOne;
                  end
               end
               default: begin
                  state_q   <= StEmpty;
                  out_vld_q <= 1'b0;
                  in_rdy_q  <= 1'b1;
               end
            endcase
         end
      end
   end else begin : g_flop
      logic              out_vld_q, out_vld_d;
      logic [DATA_W-1:0] head_data_q, head_data_d;
      logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;

      assign out_vld   = out_vld_q;
      assign in_rdy    = (!out_vld_q || out_if.ready) && !flush_i && !rst_i;
      assign head_data = head_data_q;
      assign head_ctrl = head_ctrl_q;

      // Single-entry next state: load on accept, empty on drain, bubble on flush.
      always_comb begin
         out_vld_d   = out_vld_q;
         head_data_d = head_data_q;
         head_ctrl_d = head_ctrl_q;
         if (flush_i) begin
            out_vld_d   = 1'b0;
            head_ctrl_d = '0;
         end else if (in_xfer) begin
            out_vld_d   = 1'b1;
            head_data_d = in_if.data;
            head_ctrl_d = in_if.ctrl;
         end else if (out_xfer) begin
            out_vld_d   = 1'b0;
            head_ctrl_d = '0;
         end
      end

      // Head register state update.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            out_vld_q   <= 1'b0;
            head_data_q <= '0;
            head_ctrl_q <= '0;
         end else begin
            out_vld_q   <= out_vld_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
         end
      end
   end

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of stalled output cycles; clear wins over increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cnt_clr_i) begin
         stall_cnt_d = '0;
      end else if (out_vld && !out_if.ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one skid (SKID=1) and one single-register (SKID=0) instance, CNT_W=4.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush, cnt_clr;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cur_dut  = 0;

   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4)) in_s ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4)) out_s ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4)) in_f ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4)) out_f ();

   // Index 0 = skid instance, index 1 = single-register instance.
   logic [1:0]  in_valid, out_ready;
   logic [31:0] in_data [2];
   logic [3:0]  in_ctrl [2];
   logic [1:0]  in_ready_w, out_valid_w;
   logic [31:0] out_data_w [2];
   logic [3:0]  out_ctrl_w [2];
   logic [3:0]  stall_s, stall_f;
   logic [3:0]  stall_w [2];

   assign in_s.valid  = in_valid[0];
   assign in_s.data   = in_data[0];
   assign in_s.ctrl   = in_ctrl[0];
   assign out_s.ready = out_ready[0];
   assign in_f.valid  = in_valid[1];
   assign in_f.data   = in_data[1];
   assign in_f.ctrl   = in_ctrl[1];
   assign out_f.ready = out_ready[1];

   assign in_ready_w    = {in_f.ready, in_s.ready};
   assign out_valid_w   = {out_f.valid, out_s.valid};
   assign out_data_w[0] = out_s.data;
   assign out_data_w[1] = out_f.data;
   assign out_ctrl_w[0] = out_s.ctrl;
   assign out_ctrl_w[1] = out_f.ctrl;
   assign stall_w[0]    = stall_s;
   assign stall_w[1]    = stall_f;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(4)) u_skid (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .cnt_clr_i   (cnt_clr),
      .stall_cnt_o (stall_s),
      .in_if       (in_s),
      .out_if      (out_s)
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(0), .CNT_W(4)) u_flop (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .cnt_clr_i   (cnt_clr),
      .stall_cnt_o (stall_f),
      .in_if       (in_f),
      .out_if      (out_f)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h", cur_dut, tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drv(input int d, input logic v, input logic [31:0] data, input logic [3:0] ctrl);
      in_valid[d] = v;
      in_data[d]  = data;
      in_ctrl[d]  = ctrl;
   endtask

   task automatic run_stream(input int d);
      out_ready[d] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (k < 8) drv(d, 1'b1, 32'h100 + k, 4'(k));
         else       drv(d, 1'b0, 32'h0, 4'h0);
         smp();
         if (k >= 1 && k <= 8) begin
            check("stream_valid", out_valid_w[d], 1);
            check("stream_data", out_data_w[d], 32'h100 + k - 1);
            check("stream_ctrl", out_ctrl_w[d], 32'(4'(k - 1)));
         end else begin
            check("stream_idle", out_valid_w[d], 0);
         end
         if (k < 8) check("stream_in_ready", in_ready_w[d], 1);
      end
      out_ready[d] = 1'b0;
   endtask

   task automatic run_bp_skid();
      out_ready[0] = 1'b0;
      step(); drv(0, 1'b1, 32'hA0, 4'h1);
      smp();  check("bp_rdy0", in_ready_w[0], 1);
      step(); drv(0, 1'b1, 32'hA1, 4'h2);
      smp();  check("bp_rdy1", in_ready_w[0], 1);
              check("bp_head0", out_data_w[0], 32'hA0);
      step(); drv(0, 1'b1, 32'hA2, 4'h3);
      smp();  check("bp_full_rdy", in_ready_w[0], 0);
              check("bp_full_vld", out_valid_w[0], 1);
              check("bp_full_head", out_data_w[0], 32'hA0);
      step();
      smp();  check("bp_hold_rdy", in_ready_w[0], 0);
              check("bp_hold_head", out_data_w[0], 32'hA0);
      step(); out_ready[0] = 1'b1;
      smp();  check("bp_rel_a0", out_data_w[0], 32'hA0);
      step();
      smp();  check("bp_rel_a1", out_data_w[0], 32'hA1);
              check("bp_rel_rdy", in_ready_w[0], 1);
      step(); drv(0, 1'b0, 32'h0, 4'h0);
      smp();  check("bp_rel_a2", out_data_w[0], 32'hA2);
              check("bp_rel_a2_vld", out_valid_w[0], 1);
      step();
      smp();  check("bp_drained", out_valid_w[0], 0);
      out_ready[0] = 1'b0;
   endtask

   task automatic run_bp_flop();
      out_ready[1] = 1'b0;
      step(); drv(1, 1'b1, 32'hA0, 4'h1);
      smp();  check("bp_rdy0", in_ready_w[1], 1);
      step(); drv(1, 1'b1, 32'hA1, 4'h2);
      smp();  check("bp_head0", out_data_w[1], 32'hA0);
              check("bp_stall_rdy", in_ready_w[1], 0);
      out_ready[1] = 1'b1; #1;
      check("bp_comb_rdy_hi", in_ready_w[1], 1);
      out_ready[1] = 1'b0; #1;
      check("bp_comb_rdy_lo", in_ready_w[1], 0);
      step();
      smp();  check("bp_hold_head", out_data_w[1], 32'hA0);
      step(); out_ready[1] = 1'b1;
      smp();  check("bp_rel_a0", out_data_w[1], 32'hA0);
              check("bp_rel_rdy", in_ready_w[1], 1);
      step(); drv(1, 1'b0, 32'h0, 4'h0);
      smp();  check("bp_rel_a1", out_data_w[1], 32'hA1);
              check("bp_rel_a1_vld", out_valid_w[1], 1);
      step();
      smp();  check("bp_drained", out_valid_w[1], 0);
      out_ready[1] = 1'b0;
   endtask

   task automatic run_flush(input int d);
      out_ready[d] = 1'b0;
      step(); drv(d, 1'b1, 32'h55, 4'hF);
      step(); drv(d, 1'b1, 32'h66, 4'hF);
      step(); drv(d, 1'b1, 32'h77, 4'hF);
      flush = 1'b1;
      smp();  check("fl_pre_ctrl", out_ctrl_w[d], 32'hF);
              check("fl_pre_vld", out_valid_w[d], 1);
              check("fl_in_rdy", in_ready_w[d], 0);
      step(); flush = 1'b0;
      drv(d, 1'b0, 32'h0, 4'h0);
      out_ready[d] = 1'b1;
      smp();  check("fl_vld", out_valid_w[d], 0);
              check("fl_ctrl", out_ctrl_w[d], 0);
              check("fl_rdy", in_ready_w[d], 1);
      step();
      smp();  check("fl_dropped", out_valid_w[d], 0);
      out_ready[d] = 1'b0;
   endtask

   task automatic run_cnt(input int d);
      step(); cnt_clr = 1'b1; drv(d, 1'b1, 32'h99, 4'h1); out_ready[d] = 1'b0;
      step(); cnt_clr = 1'b0; drv(d, 1'b0, 32'h0, 4'h0);
      check("cnt_cleared", stall_w[d], 0);
      check("cnt_loaded", out_valid_w[d], 1);
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 5)  check("cnt_5", stall_w[d], 5);
         if (i == 20) check("cnt_sat", stall_w[d], 15);
      end
      cnt_clr = 1'b1;
      step(); cnt_clr = 1'b0;
      check("cnt_clr_prio", stall_w[d], 0);
      step();
      check("cnt_resume", stall_w[d], 1);
      out_ready[d] = 1'b1;
      step();
      check("cnt_drain_vld", out_valid_w[d], 0);
      check("cnt_no_inc", stall_w[d], 1);
      out_ready[d] = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      cnt_clr   = 1'b0;
      in_valid  = 2'b11;
      out_ready = 2'b00;
      for (int i = 0; i < 2; i++) begin
         in_data[i] = 32'hDEAD_0000 + i;
         in_ctrl[i] = 4'hF;
      end

      for (int c = 0; c < 2; c++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            cur_dut = d;
            check("rst_vld", out_valid_w[d], 0);
            check("rst_ctrl", out_ctrl_w[d], 0);
            check("rst_cnt", stall_w[d], 0);
         end
      end
      rst      = 1'b0;
      in_valid = 2'b00;
      smp();
      for (int d = 0; d < 2; d++) begin
         cur_dut = d;
         check("rst_in_rdy", in_ready_w[d], 1);
         check("rst_post_vld", out_valid_w[d], 0);
      end

      for (int d = 0; d < 2; d++) begin
         cur_dut = d;
         run_stream(d);
         if (d == 0) run_bp_skid();
         else        run_bp_flop();
         run_flush(d);
         run_cnt(d);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
